// File: rtl/zeroriscy_axi_pkg.sv
// -----------------------------------------------------------------------------
// zeroriscy_axi_pkg
// Shared types and constants for the zeroriscy AXI4 slave memory.
//   - axi_state_e      : slave FSM state encoding (also exported for debug)
//   - RESP_*           : AXI response codes used by the slave
//   - BURST_*          : AXI burst type encodings
//   - addr_in_range()  : byte address -> "inside the memory window" test
// No ports (package).
// -----------------------------------------------------------------------------
package zeroriscy_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } axi_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // An address is valid when it is at or above the base and its word
    // offset falls inside the array. The subtraction is unsigned, so the
    // explicit lower-bound test is what rejects addresses below the base.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] words);
        logic [31:0] off;
        off = (addr - base) >> 2;
        return (addr >= base) && (off < words);
    endfunction

endpackage

// File: rtl/zeroriscy_axi_sram_array.sv
// -----------------------------------------------------------------------------
// zeroriscy_axi_sram_array
// MEM_WORDS x 32-bit register array, byte-enable synchronous write,
// combinational read. Contents are deliberately not reset.
// Ports:
//   clk_i     in   clock
//   we_i      in   write enable
//   be_i      in   [3:0] byte enables for the write
//   waddr_i   in   [AW-1:0] write word index
//   wdata_i   in   [31:0] write data
//   raddr_i   in   [AW-1:0] read word index
//   rdata_o   out  [31:0] read data (combinational)
// -----------------------------------------------------------------------------
module zeroriscy_axi_sram_array #(
    parameter  int MEM_WORDS = 16384,
    localparam int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/zeroriscy_axi_slave_mem.sv
// -----------------------------------------------------------------------------
// zeroriscy_axi_slave_mem
// AXI4 slave memory terminating the core2axi master port. Serves one
// transaction at a time (write burst or read burst), OKAY/SLVERR responses.
//
// Configuration macro: ZERORISCY_AXI_BURST_EN
//   defined   : AWLEN/ARLEN honoured (1-256 beats)
//   undefined : len treated as 0; extra write beats are accepted and dropped
//               until WLAST (BRESP=SLVERR); reads with ARLEN!=0 return one
//               beat with RLAST=1 and RRESP=SLVERR.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   S_AXI_AW*  (ADDR/LEN/SIZE/BURST/VALID in, READY out)  write address
//   S_AXI_W*   (DATA/STRB/LAST/VALID in, READY out)       write data
//   S_AXI_B*   (RESP/VALID out, READY in)                 write response
//   S_AXI_AR*  (ADDR/LEN/SIZE/BURST/VALID in, READY out)  read address
//   S_AXI_R*   (DATA/RESP/LAST/VALID out, READY in)       read data
//   dbg_state_o                      current FSM state
//
// Handshake: a transfer on any channel happens on a rising clock edge where
// VALID and READY are both high. The slave never lowers VALID or changes the
// accompanying payload before that edge; READY may be raised or lowered at
// any time and is only meaningful together with VALID.
// AWSIZE/ARSIZE are ignored: every beat is a full 32-bit word.
// -----------------------------------------------------------------------------
module zeroriscy_axi_slave_mem
    import zeroriscy_axi_pkg::*;
#(
    parameter int          MEM_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    output axi_state_e  dbg_state_o
);

`ifdef ZERORISCY_AXI_BURST_EN
    localparam logic BURST_EN = 1'b1;
`else
    localparam logic BURST_EN = 1'b0;
`endif

    localparam int AW = $clog2(MEM_WORDS);

    axi_state_e  state_q, state_d;
    logic        last_wr_q, last_wr_d;   // 1: last served channel was write
    logic [29:0] addr_q, addr_d;         // word address of the current beat
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic        aw_sel, ar_sel;
    logic [29:0] addr_nxt;
    logic [31:0] cur_addr, rd_addr;
    logic        cur_in_range, rd_in_range;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic        w_hs, beat_is_last, w_final;
    logic        ar_len_err;

    logic        unused_size;
    assign unused_size = ^{S_AXI_AWSIZE, S_AXI_ARSIZE};

    // Address selection in IDLE: round-robin only matters when both request.
    always_comb begin
        aw_sel = 1'b0;
        ar_sel = 1'b0;
        if (state_q == ST_IDLE) begin
            if (S_AXI_AWVALID && S_AXI_ARVALID) begin
                aw_sel = !last_wr_q;
                ar_sel = last_wr_q;
            end else begin
                aw_sel = S_AXI_AWVALID;
                ar_sel = S_AXI_ARVALID;
            end
        end
    end

    assign addr_nxt = ((burst_q == BURST_INCR) || (burst_q == BURST_WRAP))
                      ? addr_q + 30'd1 : addr_q;

    assign cur_addr     = {addr_q, 2'b00};
    // In IDLE the first read beat comes straight from ARADDR; afterwards the
    // array is looked up at the following beat so it can be registered on
    // the R handshake.
    assign rd_addr      = (state_q == ST_IDLE) ? S_AXI_ARADDR : {addr_nxt, 2'b00};
    assign cur_in_range = addr_in_range(cur_addr, BASE_ADDR, 32'(MEM_WORDS));
    assign rd_in_range  = addr_in_range(rd_addr, BASE_ADDR, 32'(MEM_WORDS));
    assign wr_idx       = AW'((cur_addr - BASE_ADDR) >> 2);
    assign rd_idx       = AW'((rd_addr - BASE_ADDR) >> 2);

    // With bursts disabled len_q is always 0, so beat_is_last is "first beat"
    // and the write stays open until WLAST, only the first beat is stored.
    assign w_hs         = (state_q == ST_WDATA) && S_AXI_WVALID;
    assign beat_is_last = (cnt_q == len_q);
    assign w_final      = BURST_EN ? beat_is_last : S_AXI_WLAST;
    assign mem_we       = w_hs && cur_in_range && (BURST_EN || (cnt_q == 8'd0));
    assign ar_len_err   = !BURST_EN && (S_AXI_ARLEN != 8'd0);

    zeroriscy_axi_sram_array #(
        .MEM_WORDS (MEM_WORDS)
    ) u_sram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .be_i    (S_AXI_WSTRB),
        .waddr_i (wr_idx),
        .wdata_i (S_AXI_WDATA),
        .raddr_i (rd_idx),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        case (state_q)
            ST_IDLE: begin
                if (aw_sel) begin
                    addr_d    = S_AXI_AWADDR[31:2];
                    len_d     = BURST_EN ? S_AXI_AWLEN : 8'd0;
                    burst_d   = S_AXI_AWBURST;
                    cnt_d     = 8'd0;
                    err_d     = !addr_in_range(S_AXI_AWADDR, BASE_ADDR, 32'(MEM_WORDS));
                    last_wr_d = 1'b1;
                    state_d   = ST_WDATA;
                end else if (ar_sel) begin
                    addr_d    = S_AXI_ARADDR[31:2];
                    len_d     = BURST_EN ? S_AXI_ARLEN : 8'd0;
                    burst_d   = S_AXI_ARBURST;
                    cnt_d     = 8'd0;
                    err_d     = ar_len_err;
                    last_wr_d = 1'b0;
                    rdata_d   = rd_in_range ? mem_rdata : 32'd0;
                    rresp_d   = (!rd_in_range || ar_len_err) ? RESP_SLVERR : RESP_OKAY;
                    rlast_d   = BURST_EN ? (S_AXI_ARLEN == 8'd0) : 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_WDATA: begin
                if (w_hs) begin
                    cnt_d  = cnt_q + 8'd1;
                    addr_d = addr_nxt;
                    err_d  = err_q || !cur_in_range || (S_AXI_WLAST != beat_is_last);
                    if (w_final) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                if (S_AXI_BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (S_AXI_RREADY) begin
                    if (rlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_nxt;
                        cnt_d   = cnt_q + 8'd1;
                        rdata_d = rd_in_range ? mem_rdata : 32'd0;
                        rresp_d = (!rd_in_range || err_q) ? RESP_SLVERR : RESP_OKAY;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_wr_q <= 1'b0;
            addr_q    <= 30'd0;
            len_q     <= 8'd0;
            burst_q   <= BURST_FIXED;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    assign S_AXI_AWREADY = aw_sel;
    assign S_AXI_ARREADY = ar_sel;
    assign S_AXI_WREADY  = (state_q == ST_WDATA);
    assign S_AXI_BVALID  = (state_q == ST_WRESP);
    assign S_AXI_BRESP   = (S_AXI_BVALID && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RVALID  = (state_q == ST_RDATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign dbg_state_o   = state_q;

endmodule
